// File: rtl/uart_rx_block_ctrl_pkg.sv
// Shared types and constants for the UART receive block assembler.
package uart_rx_block_ctrl_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_OUTPUT  = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    // tkeep for a block holding n received bytes: the top n bits are set,
    // because byte 0 sits in the most significant lane.
    function automatic logic [BLOCK_BYTES-1:0] keep_mask(input logic [4:0] n);
        return ~({BLOCK_BYTES{1'b1}} >> n);
    endfunction

endpackage

// File: rtl/uart_rx_block_ctrl_if.sv
// Byte stream in, 128-bit block stream out.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and the payload holds steady while
// valid is high and ready is low.
interface uart_rx_block_ctrl_if;
    import uart_rx_block_ctrl_pkg::*;

    logic [7:0]               s_axis_tdata;
    logic                     s_axis_tvalid;
    logic                     s_axis_tready;
    logic [BLOCK_BYTES*8-1:0] m_block_tdata;
    logic [BLOCK_BYTES-1:0]   m_block_tkeep;
    logic                     m_block_tvalid;
    logic                     m_block_tready;
    logic                     m_block_tlast;

    // The block controller: consumes bytes, produces blocks.
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_block_tready,
        output s_axis_tready, m_block_tdata, m_block_tkeep, m_block_tvalid, m_block_tlast
    );

    // The surroundings: the UART byte source and the block consumer.
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_block_tready,
        input  s_axis_tready, m_block_tdata, m_block_tkeep, m_block_tvalid, m_block_tlast
    );
endinterface

// File: rtl/uart_rx_block_ctrl.sv
// Packs received UART bytes into 16-byte blocks. A block closes when full or,
// optionally, when the line goes idle (padded, tlast set). Receiver errors
// throw away the partial block and skip bytes until the line goes idle.
module uart_rx_block_ctrl
    import uart_rx_block_ctrl_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE      = 8'h00,
    parameter bit         FLUSH_ON_IDLE = 1'b1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   En,
    uart_rx_block_ctrl_if.slave    bus,
    input  logic                   rx_idle,
    input  logic                   rx_frame_error,
    input  logic                   rx_parity_error,
    input  logic                   rx_overrun_error,
    output logic [4:0]             byte_cnt,
    output logic [7:0]             drop_cnt,
    output logic                   busy,
    output state_e                 state_o
);

    state_e                   state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [BLOCK_BYTES*8-1:0] data_q, data_d;
    logic [BLOCK_BYTES-1:0]   keep_q, keep_d;
    logic                     last_q, last_d;
    logic                     valid_q, valid_d;
    logic                     err_pend_q, err_pend_d;
    logic [7:0]               drop_q, drop_d;

    logic       err;
    logic       accept;
    logic [4:0] cnt_n;

    assign err    = rx_frame_error | rx_parity_error | rx_overrun_error;
    assign accept = bus.s_axis_tvalid && (state_q != ST_OUTPUT);

    // State and block registers; En low clears everything except the drop counter.
    always_ff @(posedge Clk) begin
        if (Rst || !En) begin
            state_q    <= ST_FILL;
            cnt_q      <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            last_q     <= 1'b0;
            valid_q    <= 1'b0;
            err_pend_q <= 1'b0;
            drop_q     <= Rst ? 8'h00 : drop_q;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            err_pend_q <= err_pend_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state and next-block computation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        keep_d     = keep_q;
        last_d     = last_q;
        valid_d    = valid_q;
        err_pend_d = err_pend_q;
        drop_d     = drop_q;
        cnt_n      = cnt_q;

        case (state_q)
            ST_FILL: begin
                if (err) begin
                    // Errors win over idle; a byte arriving now is lost with the block.
                    cnt_d   = '0;
                    state_d = ST_DISCARD;
                    if (((cnt_q != '0) || accept) && (drop_q != 8'hFF))
                        drop_d = drop_q + 8'd1;
                end else begin
                    cnt_n = cnt_q + {4'd0, accept};
                    if (accept)
                        data_d[{~cnt_q[3:0], 3'b000} +: 8] = bus.s_axis_tdata;
                    cnt_d = cnt_n;
                    if (cnt_n == 5'(BLOCK_BYTES)) begin
                        state_d = ST_OUTPUT;
                        valid_d = 1'b1;
                        keep_d  = '1;
                        last_d  = FLUSH_ON_IDLE && rx_idle;
                    end else if (FLUSH_ON_IDLE && rx_idle && (cnt_n != '0)) begin
                        for (int i = 0; i < BLOCK_BYTES; i++) begin
                            if (5'(i) >= cnt_n)
                                data_d[(BLOCK_BYTES-1-i)*8 +: 8] = PAD_BYTE;
                        end
                        state_d = ST_OUTPUT;
                        valid_d = 1'b1;
                        keep_d  = keep_mask(cnt_n);
                        last_d  = 1'b1;
                    end
                end
            end
            ST_OUTPUT: begin
                if (err)
                    err_pend_d = 1'b1;
                if (valid_q && bus.m_block_tready) begin
                    // An error seen while holding the block sends us to skip
                    // the rest of the corrupted message.
                    state_d    = (err_pend_q || err) ? ST_DISCARD : ST_FILL;
                    valid_d    = 1'b0;
                    cnt_d      = '0;
                    keep_d     = '0;
                    last_d     = 1'b0;
                    err_pend_d = 1'b0;
                end
            end
            ST_DISCARD: begin
                if (rx_idle)
                    state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.s_axis_tready = (state_q != ST_OUTPUT);
        busy              = (state_q != ST_FILL) || (cnt_q != '0);
    end

    assign bus.m_block_tdata  = data_q;
    assign bus.m_block_tkeep  = keep_q;
    assign bus.m_block_tlast  = last_q;
    assign bus.m_block_tvalid = valid_q;
    assign byte_cnt           = cnt_q;
    assign drop_cnt           = drop_q;
    assign state_o            = state_q;

endmodule
